// File: rtl/load_store_unit_if.sv
// Request/response and data-memory port bundle for the load/store unit.
// The slave modport is the LSU's view; master is the execute-stage/memory side.
interface load_store_unit_if #(
    parameter int ADDR_W = 48
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [63:0]       req_base;
    logic [11:0]       req_offset;
    logic [63:0]       req_wdata;
    logic              resp_valid;
    logic [63:0]       resp_rdata;
    logic              resp_fault;
    logic [ADDR_W-1:0] mem_address;
    logic [63:0]       mem_write_data;
    logic              mem_write;
    logic              mem_read;
    logic [63:0]       mem_read_data;

    modport slave (
        input  req_valid, req_write, req_funct3, req_base, req_offset, req_wdata,
        input  mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_address, mem_write_data, mem_write, mem_read
    );

    modport master (
        output req_valid, req_write, req_funct3, req_base, req_offset, req_wdata,
        output mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_address, mem_write_data, mem_write, mem_read
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: forms the effective address, checks faults, and drives a
// word-wide single-port memory, using read-modify-write for sub-word stores.
module load_store_unit #(
    parameter int ADDR_W    = 48,
    parameter int MEM_WORDS = 124
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, RESP} state_t;

    localparam logic [47:0] MEM_WORDS_W = 48'(MEM_WORDS);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          lane_q, lane_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                is_write_q, is_write_d;
    logic [63:0]         wdata_q, wdata_d;
    logic [63:0]         mem_wdata_q, mem_wdata_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic                resp_valid_q, resp_valid_d;
    logic [63:0]         resp_rdata_q, resp_rdata_d;
    logic                resp_fault_q, resp_fault_d;

    logic [63:0] eff;
    logic        out_of_range;
    logic        misaligned;
    logic        bad_funct3;
    logic        fault_now;
    logic [5:0]  shamt;
    logic [63:0] shifted;
    logic [63:0] load_val;
    logic [63:0] lane_mask;
    logic [63:0] merged;

    assign eff          = bus.req_base + {{52{bus.req_offset[11]}}, bus.req_offset};
    assign out_of_range = (eff[63:51] != 13'd0) || (eff[50:3] >= MEM_WORDS_W);
    assign bad_funct3   = (bus.req_funct3 == 3'b111) || (bus.req_write && bus.req_funct3[2]);
    assign fault_now    = out_of_range || misaligned || bad_funct3;

    always_comb begin
        misaligned = 1'b0;
        case (bus.req_funct3[1:0])
            2'b01:   misaligned = eff[0];
            2'b10:   misaligned = |eff[1:0];
            2'b11:   misaligned = |eff[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Read-word datapath: lane extraction for loads, lane merge for sub-word stores.
    assign shamt   = {lane_q, 3'b000};
    assign shifted = bus.mem_read_data >> shamt;

    always_comb begin
        load_val = 64'd0;
        case (funct3_q)
            3'b000:  load_val = {{56{shifted[7]}},  shifted[7:0]};
            3'b001:  load_val = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  load_val = {{32{shifted[31]}}, shifted[31:0]};
            3'b011:  load_val = shifted;
            3'b100:  load_val = {56'd0, shifted[7:0]};
            3'b101:  load_val = {48'd0, shifted[15:0]};
            3'b110:  load_val = {32'd0, shifted[31:0]};
            default: load_val = 64'd0;
        endcase
    end

    always_comb begin
        lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        case (funct3_q[1:0])
            2'b00:   lane_mask = 64'h0000_0000_0000_00FF;
            2'b01:   lane_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   lane_mask = 64'h0000_0000_FFFF_FFFF;
            default: lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    assign merged = (bus.mem_read_data & ~(lane_mask << shamt)) | ((wdata_q & lane_mask) << shamt);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        lane_d       = lane_q;
        funct3_d     = funct3_q;
        is_write_d   = is_write_q;
        wdata_d      = wdata_q;
        mem_wdata_d  = mem_wdata_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_fault_d = resp_fault_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d     = eff[3 +: ADDR_W];
                    lane_d     = eff[2:0];
                    funct3_d   = bus.req_funct3;
                    is_write_d = bus.req_write;
                    wdata_d    = bus.req_wdata;
                    if (fault_now) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                        resp_rdata_d = 64'd0;
                    end else if (bus.req_write && bus.req_funct3[1:0] == 2'b11) begin
                        state_d     = WR;
                        mem_write_d = 1'b1;
                        mem_wdata_d = bus.req_wdata;
                    end else begin
                        state_d    = RD;
                        mem_read_d = 1'b1;
                    end
                end
            end
            RD: state_d = RWAIT;
            RWAIT: begin
                if (is_write_q) begin
                    state_d     = WR;
                    mem_write_d = 1'b1;
                    mem_wdata_d = merged;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_fault_d = 1'b0;
                    resp_rdata_d = load_val;
                end
            end
            WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_fault_d = 1'b0;
                resp_rdata_d = 64'd0;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            lane_q       <= 3'd0;
            funct3_q     <= 3'd0;
            is_write_q   <= 1'b0;
            wdata_q      <= 64'd0;
            mem_wdata_q  <= 64'd0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 64'd0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            lane_q       <= lane_d;
            funct3_q     <= funct3_d;
            is_write_q   <= is_write_d;
            wdata_q      <= wdata_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    // Ready is masked while reset is held so every output reads 0 during reset.
    assign bus.req_ready      = rst_n & (state_q == IDLE);
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_rdata     = resp_rdata_q;
    assign bus.resp_fault     = resp_fault_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_write_data = mem_wdata_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_read       = mem_read_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural memory plus a byte-level reference
// model; directed cases from the plan followed by random requests.
module tb_load_store_unit;

    localparam int NWORDS = 124;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(48)) bus ();

    load_store_unit #(.ADDR_W(48), .MEM_WORDS(NWORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Environment memory driven by the DUT, registered read.
    logic [63:0] env_mem [0:NWORDS-1];
    logic        loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < NWORDS; i++) env_mem[i] <= 64'(i);
            loaded <= 1'b1;
        end else begin
            if (bus.mem_read)
                bus.mem_read_data <= (bus.mem_address < 48'(NWORDS)) ? env_mem[bus.mem_address] : 64'd0;
            if (bus.mem_write && bus.mem_address < 48'(NWORDS))
                env_mem[bus.mem_address] <= bus.mem_write_data;
        end
    end

    // Reference memory, handled a byte at a time.
    logic [63:0] ref_mem [0:NWORDS-1];
    int checks = 0;
    int errors = 0;
    int txn    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_load(input logic [63:0] eff, input logic [2:0] f3);
        int size;
        logic [63:0] v, a;
        logic [7:0] b;
        size = 1 << f3[1:0];
        v = 64'd0;
        for (int k = 0; k < size; k++) begin
            a = eff + 64'(k);
            b = ref_mem[a[50:3]][8*a[2:0] +: 8];
            v = v | (64'(b) << (8*k));
        end
        if (!f3[2] && size < 8 && v[8*size-1]) v = v | (~64'd0 << (8*size));
        return v;
    endfunction

    task automatic ref_store(input logic [63:0] eff, input logic [2:0] f3, input logic [63:0] wd);
        int size;
        logic [63:0] a;
        size = 1 << f3[1:0];
        for (int k = 0; k < size; k++) begin
            a = eff + 64'(k);
            ref_mem[a[50:3]][8*a[2:0] +: 8] = wd[8*k +: 8];
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
        chk({tag, "_resp_fault"}, 64'(bus.resp_fault), 64'd0);
        chk({tag, "_resp_rdata"}, bus.resp_rdata, 64'd0);
        chk({tag, "_mem_address"}, 64'(bus.mem_address), 64'd0);
        chk({tag, "_mem_wdata"}, bus.mem_write_data, 64'd0);
        chk({tag, "_mem_write"}, 64'(bus.mem_write), 64'd0);
        chk({tag, "_mem_read"}, 64'(bus.mem_read), 64'd0);
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    endtask

    task automatic randomize_req_fields();
        bus.req_write  = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_base   = {$urandom, $urandom};
        bus.req_offset = 12'($urandom);
        bus.req_wdata  = {$urandom, $urandom};
    endtask

    // One full transaction: drive, accept, watch cycles 1..lat+1, compare with the model.
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [63:0] base,
                          input logic [11:0] off, input logic [63:0] wd,
                          output logic [63:0] o_rdata, output logic [63:0] o_wdata);
        logic [63:0] eff, exp_rdata, idx, hold, wr_addr, o_addr;
        logic [7:0]  rv_m, rd_m, wr_m, rdy_m, exp_rd, exp_wr;
        logic        fault, o_fault;
        int size, lat;
        eff  = base + {{52{off[11]}}, off};
        idx  = {16'd0, eff[50:3]};
        size = 1 << f3[1:0];
        fault = (eff[63:51] != 0) || (idx >= 64'(NWORDS)) || ((int'(eff[2:0]) % size) != 0)
                || (f3 == 3'b111) || (w && f3[2]);
        if (fault)          lat = 1;
        else if (!w)        lat = 3;
        else if (size == 8) lat = 2;
        else                lat = 4;
        exp_rdata = (fault || w) ? 64'd0 : ref_load(eff, f3);
        exp_rd = (!fault && !(w && size == 8)) ? 8'b0000_0010 : 8'd0;
        exp_wr = (fault || !w) ? 8'd0 : ((size == 8) ? 8'b0000_0010 : 8'b0000_1000);
        rv_m = 0; rd_m = 0; wr_m = 0; rdy_m = 0;
        wr_addr = 0; o_wdata = 0; o_rdata = 0; o_fault = 0; o_addr = 0; hold = 0;

        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_base   = base;
        bus.req_offset = off;
        bus.req_wdata  = wd;
        chk("req_ready_before", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        randomize_req_fields();
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (bus.resp_valid) rv_m[k]  = 1'b1;
            if (bus.mem_read)   rd_m[k]  = 1'b1;
            if (bus.req_ready)  rdy_m[k] = 1'b1;
            if (bus.mem_write) begin
                wr_m[k] = 1'b1;
                wr_addr = 64'(bus.mem_address);
                o_wdata = bus.mem_write_data;
            end
            if (k == lat) begin
                o_rdata = bus.resp_rdata;
                o_fault = bus.resp_fault;
                o_addr  = 64'(bus.mem_address);
            end
            if (k == lat + 1) hold = bus.resp_rdata;
        end
        if (w && !fault) ref_store(eff, f3, wd);

        chk("resp_valid_cycle", 64'(rv_m), 64'(8'd1 << lat));
        chk("mem_read_cycles", 64'(rd_m), 64'(exp_rd));
        chk("mem_write_cycles", 64'(wr_m), 64'(exp_wr));
        chk("req_ready_cycles", 64'(rdy_m), 64'(8'd1 << (lat + 1)));
        chk("resp_fault", 64'(o_fault), 64'(fault));
        chk("resp_rdata", o_rdata, exp_rdata);
        chk("resp_rdata_hold", hold, exp_rdata);
        if (!fault) chk("mem_address", o_addr, idx);
        if (w && !fault) begin
            chk("write_address", wr_addr, idx);
            chk("write_data", o_wdata, ref_mem[idx]);
        end
        txn++;
        $display("txn %0d: %s f3=%0d eff=0x%h fault=%0b rdata=0x%h wdata=0x%h",
                 txn, w ? "store" : "load ", f3, eff, o_fault, o_rdata, o_wdata);
    endtask

    initial begin
        logic [63:0] rd, wdo, base;
        logic [11:0] off;
        logic [2:0]  f3;
        logic        w;
        logic [7:0]  wr_seen;

        for (int i = 0; i < NWORDS; i++) ref_mem[i] = 64'(i);
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        randomize_req_fields();

        // Reset state and release.
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        #1;
        chk("reset_release_ready", 64'(bus.req_ready), 64'd1);

        // Load D.
        do_req(1'b0, 3'b011, 64'h40, 12'd8, 64'd0, rd, wdo);
        chk("ld_word9", rd, 64'd9);

        // Sub-word store then sign/zero-extended loads.
        do_req(1'b1, 3'b000, 64'h51, 12'd0, 64'hAB, rd, wdo);
        chk("sb_merged_word", wdo, 64'h0000_0000_0000_AB0A);
        do_req(1'b0, 3'b000, 64'h51, 12'd0, 64'd0, rd, wdo);
        chk("lb_signed", rd, 64'hFFFF_FFFF_FFFF_FFAB);
        do_req(1'b0, 3'b100, 64'h51, 12'd0, 64'd0, rd, wdo);
        chk("lbu_zero", rd, 64'h0000_0000_0000_00AB);

        // Store D with negative offset, then word loads.
        do_req(1'b1, 3'b011, 64'h20, 12'hFF8, 64'hDEAD_BEEF_CAFE_F00D, rd, wdo);
        chk("sd_data", wdo, 64'hDEAD_BEEF_CAFE_F00D);
        do_req(1'b0, 3'b010, 64'h1C, 12'd0, 64'd0, rd, wdo);
        chk("lw_signed", rd, 64'hFFFF_FFFF_DEAD_BEEF);
        do_req(1'b0, 3'b110, 64'h1C, 12'd0, 64'd0, rd, wdo);
        chk("lwu_zero", rd, 64'h0000_0000_DEAD_BEEF);

        // Faults.
        do_req(1'b0, 3'b010, 64'h42, 12'd0, 64'd0, rd, wdo);
        do_req(1'b0, 3'b011, 64'h3E0, 12'd0, 64'd0, rd, wdo);
        do_req(1'b0, 3'b111, 64'h10, 12'd0, 64'd0, rd, wdo);
        do_req(1'b1, 3'b100, 64'h10, 12'd0, 64'h55, rd, wdo);
        do_req(1'b0, 3'b011, 64'h0008_0000_0000_0000, 12'd0, 64'd0, rd, wdo);

        // Reset during RWAIT of a halfword store to word 5: no write, no response.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'b001;
        bus.req_base   = 64'h28;
        bus.req_offset = 12'd2;
        bus.req_wdata  = 64'h1234;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("midrst_mem_read_c1", 64'(bus.mem_read), 64'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        wr_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.mem_write) wr_seen[k] = 1'b1;
            if (bus.resp_valid) wr_seen[k+4] = 1'b1;
        end
        chk("midrst_no_write_no_resp", 64'(wr_seen), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("midrst_release_ready", 64'(bus.req_ready), 64'd1);
        do_req(1'b0, 3'b011, 64'h28, 12'd0, 64'd0, rd, wdo);
        chk("ld_word5_after_rst", rd, 64'd5);

        // Random requests against the reference model.
        for (int n = 0; n < 80; n++) begin
            w    = 1'($urandom);
            f3   = 3'($urandom_range(0, 7));
            base = 64'($urandom_range(0, 32'h420));
            off  = 12'($urandom);
            if ($urandom_range(0, 15) == 0) base = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) begin
                base = base & ~(64'd7);
                off  = off & ~(12'd7);
            end
            do_req(w, f3, base, off, {$urandom, $urandom}, rd, wdo);
        end

        // Final sweep: DUT-written memory matches the model word for word.
        for (int i = 0; i < NWORDS; i++) chk($sformatf("mem_word_%0d", i), env_mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
